// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM controller: register offsets, CTRL/STATUS
// field positions and the per-channel state record.
package led_pwm_pkg;

   // Channel state is sized by this constant; the top's CNT_W must match it.
   localparam int PWM_CNT_W = 8;

   localparam logic [5:0] ADDR_CTRL      = 6'h00;
   localparam logic [5:0] ADDR_PRESCALE  = 6'h04;
   localparam logic [5:0] ADDR_STATUS    = 6'h08;
   localparam logic [5:0] ADDR_DUTY_BASE = 6'h10;

   localparam int CTRL_EN_LSB   = 0;
   localparam int CTRL_BRE_LSB  = 16;
   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_WRAP_BIT = 1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   typedef struct packed {
      logic [PWM_CNT_W-1:0] duty;
      logic [PWM_CNT_W-1:0] shadow;
      dir_e                 dir;
   } ch_state_t;

endpackage

// File: rtl/pwm_channel.sv
// One LED PWM channel: shadow and effective duty, breathe ramp, registered compare.
//
//   state    | meaning
//   DIR_UP   | breathe ramp climbing toward full duty (held here outside breathe)
//   DIR_DOWN | breathe ramp falling toward zero duty
module pwm_channel
   import led_pwm_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wrap_i,
   input  logic                 duty_we_i,
   input  logic [PWM_CNT_W-1:0] duty_wdata_i,
   input  logic                 ch_en_i,
   input  logic                 breathe_en_i,
   input  logic [PWM_CNT_W-1:0] cnt_i,
   output logic [PWM_CNT_W-1:0] shadow_o,
   output logic                 pwm_o
);

   localparam logic [PWM_CNT_W-1:0] DUTY_MAX = '1;
   localparam logic [PWM_CNT_W-1:0] ONE      = PWM_CNT_W'(1);

   ch_state_t st_q;
   logic      on_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= '{duty: '0, shadow: '0, dir: DIR_UP};
         on_q <= 1'b0;
      end else begin
         if (duty_we_i && !breathe_en_i) begin
            st_q.shadow <= duty_wdata_i;
         end
         if (!breathe_en_i) begin
            st_q.dir <= DIR_UP;
         end
         // Effective duty only moves on a period boundary, so a period is never cut short.
         if (wrap_i) begin
            if (!breathe_en_i) begin
               st_q.duty <= st_q.shadow;
            end else if (st_q.dir == DIR_UP) begin
               if (st_q.duty == DUTY_MAX) begin
                  st_q.dir  <= DIR_DOWN;
                  st_q.duty <= st_q.duty - ONE;
               end else begin
                  st_q.duty <= st_q.duty + ONE;
               end
            end else begin
               if (st_q.duty == '0) begin
                  st_q.dir  <= DIR_UP;
                  st_q.duty <= st_q.duty + ONE;
               end else begin
                  st_q.duty <= st_q.duty - ONE;
               end
            end
         end
         on_q <= (cnt_i < st_q.duty);
      end
   end

   assign shadow_o = st_q.shadow;
   // Enable gates the registered compare so disabling takes effect with the CTRL register.
   assign pwm_o    = ACTIVE_LOW ^ (ch_en_i & on_q);

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED PWM controller: register file and bus decode, shared prescaler
// and period counter, and one pwm_channel per LED output.
module led_pwm_ctrl
   import led_pwm_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = PWM_CNT_W,
   parameter int PRESCALE_W = 16,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic              we,
   input  logic [5:0]        addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [NUM_CH-1:0] pwm_o,
   output logic              wrap_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** CNT_W) - 2);

   logic [3:0]            widx;
   logic [3:0]            duty_idx;
   logic                  wr;
   logic                  rd;
   logic                  hit_ctrl;
   logic                  hit_presc;
   logic                  hit_status;
   logic                  hit_duty;
   logic                  wrap_clr;
   logic [NUM_CH-1:0]     ch_en_q;
   logic [NUM_CH-1:0]     breathe_q;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [PRESCALE_W-1:0] presc_cnt_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  tick;
   logic                  wrap;
   logic                  wrap_q;
   logic                  sticky_q;
   logic [31:0]           rdata_d;
   logic [31:0]           rdata_q;
   logic [PWM_CNT_W-1:0]  shadow [NUM_CH];
   logic                  unused_bits;

   assign widx       = addr[5:2];
   assign wr         = sel & we;
   assign rd         = sel & ~we;
   assign hit_ctrl   = (widx == ADDR_CTRL[5:2]);
   assign hit_presc  = (widx == ADDR_PRESCALE[5:2]);
   assign hit_status = (widx == ADDR_STATUS[5:2]);
   assign duty_idx   = widx - ADDR_DUTY_BASE[5:2];
   assign hit_duty   = (widx >= ADDR_DUTY_BASE[5:2]) && (duty_idx < 4'(NUM_CH));
   assign wrap_clr   = wr & hit_status & wdata[STAT_WRAP_BIT];

   assign unused_bits = ^{wdata[31:CTRL_BRE_LSB+NUM_CH], addr[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_en_q    <= '0;
         breathe_q  <= '0;
         prescale_q <= '0;
      end else if (wr) begin
         if (hit_ctrl) begin
            ch_en_q   <= wdata[CTRL_EN_LSB +: NUM_CH];
            breathe_q <= wdata[CTRL_BRE_LSB +: NUM_CH];
         end
         if (hit_presc) begin
            prescale_q <= wdata[PRESCALE_W-1:0];
         end
      end
   end

   assign tick = (presc_cnt_q == prescale_q);
   assign wrap = tick && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt_q <= '0;
         cnt_q       <= '0;
         wrap_q      <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         // A new PRESCALE value restarts the tick phase from zero.
         if ((wr && hit_presc) || tick) begin
            presc_cnt_q <= '0;
         end else begin
            presc_cnt_q <= presc_cnt_q + PRESCALE_W'(1);
         end
         if (tick) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         end
         wrap_q   <= wrap;
         sticky_q <= wrap | (sticky_q & ~wrap_clr);
      end
   end

   always_comb begin
      rdata_d = '0;
      if (hit_ctrl) begin
         rdata_d[CTRL_EN_LSB +: NUM_CH]  = ch_en_q;
         rdata_d[CTRL_BRE_LSB +: NUM_CH] = breathe_q;
      end else if (hit_presc) begin
         rdata_d[PRESCALE_W-1:0] = prescale_q;
      end else if (hit_status) begin
         rdata_d[STAT_BUSY_BIT] = |ch_en_q;
         rdata_d[STAT_WRAP_BIT] = sticky_q;
      end else if (hit_duty) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (duty_idx == 4'(i)) begin
               rdata_d[PWM_CNT_W-1:0] = shadow[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (rd) begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata  = rdata_q;
   assign wrap_o = wrap_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pwm_channel #(
         .ACTIVE_LOW(ACTIVE_LOW)
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .wrap_i       (wrap),
         .duty_we_i    (wr && hit_duty && (duty_idx == 4'(i))),
         .duty_wdata_i (wdata[PWM_CNT_W-1:0]),
         .ch_en_i      (ch_en_q[i]),
         .breathe_en_i (breathe_q[i]),
         .cnt_i        (cnt_q),
         .shadow_o     (shadow[i]),
         .pwm_o        (pwm_o[i])
      );
   end

endmodule
